// File: rtl/capture_trigger_ctrl.sv
// rtl/capture_trigger_ctrl.sv - decimating capture with level/slope trigger and vblank-synchronised bank swap
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   adc_data/valid    incoming 12-bit sample stream
//   decim             keep one of every decim+1 valid samples
//   trig_level/slope  trigger threshold and edge (0 rising, 1 falling)
//   trig_mode         00 normal, 01 auto, 10 single, 11 normal
//   run               level enable; low aborts the capture
//   vblnk             vertical blank, swap point for the display bank
//   wr_en/bank/addr/data  write port into the back bank
//   disp_bank/start   bank and oldest-sample address the display reads
//   frame_swap        one-cycle pulse on each bank swap
//   triggered         1 if the displayed capture came from a real crossing
//   state             FSM state for debug
module capture_trigger_ctrl #(
  parameter int DEPTH        = 512,
  parameter int PRE          = 128,
  parameter int AUTO_TIMEOUT = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [11:0]              adc_data,
  input  logic                     adc_valid,
  input  logic [3:0]               decim,
  input  logic [11:0]              trig_level,
  input  logic                     trig_slope,
  input  logic [1:0]               trig_mode,
  input  logic                     run,
  input  logic                     vblnk,
  output logic                     wr_en,
  output logic                     wr_bank,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [11:0]              wr_data,
  output logic                     disp_bank,
  output logic [$clog2(DEPTH)-1:0] disp_start,
  output logic                     frame_swap,
  output logic                     triggered,
  output logic [2:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(AUTO_TIMEOUT + DEPTH) + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE - 1);
  localparam logic [CW-1:0] AUTO_LAST = CW'(AUTO_TIMEOUT - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE - 2);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRETRIG   = 3'd1,
    ARMED     = 3'd2,
    POST      = 3'd3,
    WAIT_SWAP = 3'd4
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic [3:0]      dcnt;
  logic [AW-1:0]   wr_ptr;
  logic [11:0]     prev;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   t_addr;
  logic            trig_flag;
  logic [AW-1:0]   start_pend;
  logic            vblnk_q;
  logic            rearm_ok;

  logic accept;
  logic crossing;
  logic mode_auto;
  logic mode_single;
  logic auto_fire;
  logic vblnk_edge;
  logic do_write;
  logic do_swap;
  logic take_trig;
  logic enter_wait;

  assign accept      = adc_valid && (dcnt == decim);
  assign mode_auto   = (trig_mode == 2'b01);
  assign mode_single = (trig_mode == 2'b10);
  assign vblnk_edge  = vblnk && !vblnk_q;
  // cnt saturates, so switching to auto after a long normal wait fires on the next sample
  assign auto_fire   = mode_auto && (cnt >= AUTO_LAST);
  assign crossing    = trig_slope ? ((prev > trig_level) && (trig_level >= adc_data))
                                  : ((prev < trig_level) && (trig_level <= adc_data));
  assign state       = cur_state;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (!run) begin
      nxt_state = IDLE;
    end else begin
      case (cur_state)
        IDLE:      if (!mode_single || rearm_ok) nxt_state = PRETRIG;
        PRETRIG:   if (accept && cnt == PRE_LAST) nxt_state = ARMED;
        ARMED:     if (accept && (crossing || auto_fire)) nxt_state = POST;
        POST:      if (accept && cnt == POST_LAST) nxt_state = WAIT_SWAP;
        WAIT_SWAP: if (vblnk_edge) nxt_state = mode_single ? IDLE : PRETRIG;
        default:   nxt_state = IDLE;
      endcase
    end
  end

  always_comb begin
    do_write   = accept && ((cur_state == PRETRIG) || (cur_state == ARMED) || (cur_state == POST));
    take_trig  = run && accept && (cur_state == ARMED) && (crossing || auto_fire);
    enter_wait = (cur_state == POST) && (nxt_state == WAIT_SWAP);
    // abort has priority: with run low no swap is taken even on a vblank edge
    do_swap    = run && vblnk_edge && (cur_state == WAIT_SWAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_bank    <= 1'b1;
      wr_addr    <= '0;
      wr_data    <= '0;
      disp_bank  <= 1'b0;
      disp_start <= '0;
      frame_swap <= 1'b0;
      triggered  <= 1'b0;
      dcnt       <= '0;
      wr_ptr     <= '0;
      prev       <= '0;
      cnt        <= '0;
      t_addr     <= '0;
      trig_flag  <= 1'b0;
      start_pend <= '0;
      vblnk_q    <= 1'b0;
      rearm_ok   <= 1'b1;
    end else begin
      vblnk_q    <= vblnk;
      wr_en      <= do_write;
      frame_swap <= do_swap;

      if (do_write) begin
        wr_addr <= wr_ptr;
        wr_data <= adc_data;
        wr_ptr  <= wr_ptr + 1'b1;
        prev    <= adc_data;
      end

      if (cur_state != PRETRIG && nxt_state == PRETRIG) dcnt <= '0;
      else if (adc_valid) dcnt <= accept ? 4'd0 : dcnt + 4'd1;

      // per-state sample counter: PRETRIG fill, ARMED timeout, POST fill
      if (nxt_state != cur_state) cnt <= '0;
      else if (do_write && cnt != '1) cnt <= cnt + 1'b1;

      if (take_trig) begin
        t_addr    <= wr_ptr;
        trig_flag <= crossing;
      end

      if (enter_wait) start_pend <= t_addr - PRE_OFS;

      if (do_swap) begin
        disp_bank  <= !disp_bank;
        wr_bank    <= disp_bank;
        disp_start <= start_pend;
        triggered  <= trig_flag;
      end

      if (!run) rearm_ok <= 1'b1;
      else if (do_swap && mode_single) rearm_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// tb/tb_capture_trigger_ctrl.sv - directed self-checking bench for capture_trigger_ctrl
module tb_capture_trigger_ctrl;

  localparam int DEPTH = 512;
  localparam int PRE   = 128;
  localparam int AUTO  = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [3:0]  decim;
  logic [11:0] trig_level;
  logic        trig_slope;
  logic [1:0]  trig_mode;
  logic        run;
  logic        vblnk;
  logic        wr_en;
  logic        wr_bank;
  logic [8:0]  wr_addr;
  logic [11:0] wr_data;
  logic        disp_bank;
  logic [8:0]  disp_start;
  logic        frame_swap;
  logic        triggered;
  logic [2:0]  state;

  always #5 clk = ~clk;

  capture_trigger_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .decim      (decim),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .trig_mode  (trig_mode),
    .run        (run),
    .vblnk      (vblnk),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_bank  (disp_bank),
    .disp_start (disp_start),
    .frame_swap (frame_swap),
    .triggered  (triggered),
    .state      (state)
  );

  typedef struct {
    logic [8:0]  addr;
    logic [11:0] data;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          exp_ptr  = 0;
  int          wr_count = 0;
  logic [11:0] mem [0:1][0:511];
  logic        exp_disp_bank  = 1'b0;
  int          exp_disp_start = 0;
  logic        exp_trig       = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
      check("wr_bank_is_back", 32'(wr_bank), 32'(!disp_bank));
      mem[wr_bank][wr_addr] = wr_data;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] wave(input int kind, input int j);
    int v;
    case (kind)
      0:       v = (j * 16) % 4096;
      1:       v = ((j / 15) % 2 == 0) ? 4000 : 0;
      2:       v = 100;
      default: v = ((j % 64) < 32) ? 500 + (j % 64) * 100 : 500 + (64 - (j % 64)) * 100;
    endcase
    return 12'(v);
  endfunction

  // index of the first sample in ARMED (indices from PRETRIG start) meeting the crossing rule
  function automatic int first_cross(input int kind, input logic slope, input logic [11:0] level);
    logic [11:0] pv, cv;
    for (int j = PRE; j < PRE + AUTO; j++) begin
      pv = wave(kind, j - 1);
      cv = wave(kind, j);
      if (!slope && pv < level && level <= cv) return j;
      if (slope && pv > level && level >= cv) return j;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [11:0] v, input bit expw);
    adc_data  = v;
    adc_valid = 1'b1;
    if (expw) begin
      exp_q.push_back('{9'(exp_ptr), v});
      exp_ptr = (exp_ptr + 1) % DEPTH;
    end
    tick();
  endtask

  task automatic capture(input int kind, input logic slope, input logic [11:0] level,
                         input bit vb_on_entry, output int ds, output logic real_trig);
    int t_idx, total, ptr0, n;
    trig_slope = slope;
    trig_level = level;
    ptr0  = exp_ptr;
    t_idx = first_cross(kind, slope, level);
    real_trig = (t_idx >= 0);
    if (t_idx < 0) t_idx = PRE + AUTO - 1;
    total = t_idx + 1 + (DEPTH - PRE - 1);
    ds = (ptr0 + t_idx - PRE + 2 * DEPTH) % DEPTH;
    for (int k = 0; k < total; k++) begin
      if (vb_on_entry && k == total - 1) vblnk = 1'b1;
      feed(wave(kind, k), 1'b1);
      n = k + 1;
      if (n == PRE - 1) check("state_pretrig", 32'(state), 32'd1);
      if (n == PRE)     check("state_armed", 32'(state), 32'd2);
      if (n == t_idx)   check("state_before_trig", 32'(state), 32'd2);
      if (n == t_idx + 1) check("state_post", 32'(state), 32'd3);
      if (n == total)   check("state_wait_swap", 32'(state), 32'd4);
    end
    adc_valid = 1'b0;
  endtask

  task automatic vblank_pulse(input bit exp_swap, input logic [2:0] exp_state);
    vblnk = 1'b1;
    tick();
    check("frame_swap", 32'(frame_swap), 32'(exp_swap));
    check("disp_bank", 32'(disp_bank), 32'(exp_disp_bank));
    check("disp_start", 32'(disp_start), 32'(exp_disp_start));
    check("triggered", 32'(triggered), 32'(exp_trig));
    check("wr_bank", 32'(wr_bank), 32'(!exp_disp_bank));
    check("state_after_vblank", 32'(state), 32'(exp_state));
    vblnk = 1'b0;
    tick();
    check("frame_swap_pulse_end", 32'(frame_swap), 32'd0);
  endtask

  int   ds;
  logic rt;
  int   wc0;

  initial begin
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; decim = 4'd0; trig_level = 12'd2048;
    trig_slope = 1'b0; trig_mode = 2'b00; run = 1'b0; vblnk = 1'b0;
    tick(); tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_wr_bank", 32'(wr_bank), 32'd1);
    check("rst_disp_bank", 32'(disp_bank), 32'd0);
    check("rst_disp_start", 32'(disp_start), 32'd0);
    check("rst_frame_swap", 32'(frame_swap), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_without_run", 32'(state), 32'd0);

    // ramp, normal, rising at 2048
    run = 1'b1;
    tick();
    check("run_to_pretrig", 32'(state), 32'd1);
    capture(0, 1'b0, 12'd2048, 1'b0, ds, rt);
    tick();
    check("wait_no_swap", 32'(frame_swap), 32'd0);
    exp_disp_bank = 1'b1; exp_disp_start = ds; exp_trig = rt;
    vblank_pulse(1'b1, 3'd1);
    check("ramp_trig_sample", 32'(mem[exp_disp_bank][(ds + PRE) % DEPTH]), 32'd2048);
    check("ramp_pre_sample", 32'(mem[exp_disp_bank][(ds + PRE - 1) % DEPTH]), 32'd2032);
    check("ramp_oldest", 32'(mem[exp_disp_bank][ds]), 32'd0);

    // square wave, falling at 2000
    capture(1, 1'b1, 12'd2000, 1'b0, ds, rt);
    exp_disp_bank = 1'b0; exp_disp_start = ds; exp_trig = rt;
    vblank_pulse(1'b1, 3'd1);
    check("square_trig_zero", 32'(mem[exp_disp_bank][(ds + PRE) % DEPTH]), 32'd0);
    check("square_pre_high", 32'(mem[exp_disp_bank][(ds + PRE - 1) % DEPTH]), 32'd4000);

    // DC in auto mode; a vblank edge on WAIT_SWAP entry is ignored
    trig_mode = 2'b01;
    capture(2, 1'b0, 12'd2048, 1'b1, ds, rt);
    tick();
    check("entry_edge_ignored", 32'(frame_swap), 32'd0);
    check("entry_edge_state", 32'(state), 32'd4);
    vblnk = 1'b0;
    tick();
    exp_disp_bank = 1'b1; exp_disp_start = ds; exp_trig = rt;
    vblank_pulse(1'b1, 3'd1);
    check("auto_triggered_flag", 32'(triggered), 32'd0);

    // decimation by 4 across the address wrap
    trig_mode = 2'b00;
    decim = 4'd3;
    wc0 = wr_count;
    for (int i = 0; i < 2080; i++) feed(12'(i % 2048), (i % 4) == 3);
    adc_valid = 1'b0;
    tick();
    check("decim_write_count", 32'(wr_count - wc0), 32'd520);
    check("decim_state_armed", 32'(state), 32'd2);

    // crossing, then run dropped during POST
    decim = 4'd0;
    feed(12'd3000, 1'b1);
    check("post_after_cross", 32'(state), 32'd3);
    for (int i = 0; i < 10; i++) feed(12'd3000, 1'b1);
    adc_valid = 1'b0;
    run = 1'b0;
    tick();
    check("abort_to_idle", 32'(state), 32'd0);
    vblank_pulse(1'b0, 3'd0);

    // single mode: one swap, no rearm until run toggles
    trig_mode = 2'b10;
    run = 1'b1;
    tick();
    check("single_start", 32'(state), 32'd1);
    capture(3, 1'b0, 12'd2048, 1'b0, ds, rt);
    exp_disp_bank = 1'b0; exp_disp_start = ds; exp_trig = rt;
    vblank_pulse(1'b1, 3'd0);
    for (int i = 0; i < 20; i++) feed(wave(3, i), 1'b0);
    adc_valid = 1'b0;
    check("single_stays_idle", 32'(state), 32'd0);
    vblank_pulse(1'b0, 3'd0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    check("single_rearm", 32'(state), 32'd1);
    run = 1'b0;
    tick();
    tick();
    check("final_idle", 32'(state), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
